// File: rtl/input_irq_sequencer_if.sv
// Register-port bundle between the interrupt sequencer and the input controller.
//   master (sequencer): drives we, register_addr, wr_data; receives irq, rd_data, done.
//   slave (controller): the mirror image.
interface input_irq_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  irq;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  done;
  logic                  we;
  logic [1:0]            register_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    input  irq,
    input  rd_data,
    input  done,
    output we,
    output register_addr,
    output wr_data
  );

  modport slave (
    output irq,
    output rd_data,
    output done,
    input  we,
    input  register_addr,
    input  wr_data
  );
endinterface

// File: rtl/input_irq_sequencer.sv
// Interrupt service sequencer for the input controller register port.
// On irq it reads the edge-capture register (addr 1), queues the non-zero edge snapshot in
// an event FIFO, then writes the same bits to the edge-clear register (addr 3), which drops
// irq without CPU involvement. Game logic pops events from the FIFO.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (master)      controller register port: irq, rd_data, done in; we, register_addr,
//                     wr_data out
//   evt_data/valid    FIFO head snapshot and non-empty flag
//   evt_ready         consumer pop (pop when evt_valid && evt_ready)
//   evt_ts            head timestamp (0 unless INPUT_IRQ_SEQ_TIMESTAMP_EN is defined)
//   overflow          sticky, an event was dropped on a full FIFO
//   timeout_err       sticky, a clear write was not acknowledged within TIMEOUT cycles
//   busy              registered, high while a service sequence is in progress
//   clr_err           synchronous clear of the sticky error flags
//
// Build option: define INPUT_IRQ_SEQ_TIMESTAMP_EN to add a 32-bit free-running cycle
// counter whose value in the READ cycle is stored with each event.
module input_irq_sequencer #(
  parameter int unsigned NUM_INPUTS = 12,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned SETTLE     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input_irq_sequencer_if.master bus,
  output logic [NUM_INPUTS-1:0] evt_data,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [31:0]           evt_ts,
  output logic                  overflow,
  output logic                  timeout_err,
  output logic                  busy,
  input  logic                  clr_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] AddrData  = 2'd1;
  localparam logic [1:0] AddrClear = 2'd3;

  typedef enum logic [1:0] {StIdle, StRead, StClear, StSettle} state_e;

  state_e                state_q, state_d;
  logic [NUM_INPUTS-1:0] snap_q, snap_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [SW-1:0]         settle_q, settle_d;
  logic                  overflow_q, overflow_d;
  logic                  timeout_q, timeout_d;
  logic                  busy_q, busy_d;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [NUM_INPUTS-1:0] mem_q [DEPTH];
  logic [NUM_INPUTS-1:0] mem_d [DEPTH];

  logic fifo_full, fifo_empty;
  logic push_req, push, pop;
  logic ovf_set, tmo_set;

  logic unused_rd;
  assign unused_rd = ^bus.rd_data[DATA_WIDTH-1:NUM_INPUTS];

  // ---------------------------------------------------------------------------------------
  // FIFO status
  // ---------------------------------------------------------------------------------------
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = !fifo_empty && evt_ready;

  // ---------------------------------------------------------------------------------------
  // Sequencer FSM and error flags
  // ---------------------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    tmo_d      = tmo_q;
    settle_d   = settle_q;
    push_req   = 1'b0;
    tmo_set    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.irq) state_d = StRead;
      end
      StRead: begin
        snap_d = bus.rd_data[NUM_INPUTS-1:0];
        if (snap_d == '0) begin
          // Spurious interrupt: nothing to queue or clear.
          state_d  = StSettle;
          settle_d = '0;
        end else begin
          push_req = 1'b1;
          state_d  = StClear;
          tmo_d    = '0;
        end
      end
      StClear: begin
        // tmo_q + 1 is the number of CLEAR cycles seen including this one.
        if (bus.done) begin
          state_d  = StSettle;
          settle_d = '0;
        end else if (tmo_q + TW'(1) == TW'(TIMEOUT)) begin
          tmo_set  = 1'b1;
          state_d  = StSettle;
          settle_d = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StSettle: begin
        if (settle_q == SW'(SETTLE - 1)) state_d = StIdle;
        else                             settle_d = settle_q + SW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  // A full FIFO still accepts a push when the consumer pops in the same cycle.
  assign push    = push_req && (!fifo_full || pop);
  assign ovf_set = push_req && fifo_full && !pop;

  // Set beats clear when both land in the same cycle.
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_set)      overflow_d = 1'b1;
    else if (clr_err) overflow_d = 1'b0;

    timeout_d = timeout_q;
    if (tmo_set)      timeout_d = 1'b1;
    else if (clr_err) timeout_d = 1'b0;
  end

  // Busy also covers the cycle in which IDLE is re-entered, so it spans the whole
  // IDLE-to-IDLE sequence as seen from the consumer side.
  assign busy_d = (state_d != StIdle) || (state_q != StIdle);

  // ---------------------------------------------------------------------------------------
  // FIFO next state
  // ---------------------------------------------------------------------------------------
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = snap_d;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      snap_q     <= '0;
      tmo_q      <= '0;
      settle_q   <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      tmo_q      <= tmo_d;
      settle_q   <= settle_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_q      <= mem_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Optional timestamp lane
  // ---------------------------------------------------------------------------------------
`ifdef INPUT_IRQ_SEQ_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d;
  logic [31:0] ts_mem_q [DEPTH];
  logic [31:0] ts_mem_d [DEPTH];

  always_comb begin
    ts_d     = ts_q + 32'd1;
    ts_mem_d = ts_mem_q;
    if (push) ts_mem_d[wr_ptr_q[AW-1:0]] = ts_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q     <= '0;
      ts_mem_q <= '{default: '0};
    end else begin
      ts_q     <= ts_d;
      ts_mem_q <= ts_mem_d;
    end
  end

  assign evt_ts = ts_mem_q[rd_ptr_q[AW-1:0]];
`else
  assign evt_ts = '0;
`endif

  // ---------------------------------------------------------------------------------------
  // Outputs; decoded from state so reset drops we asynchronously.
  // ---------------------------------------------------------------------------------------
  assign bus.we            = (state_q == StClear);
  assign bus.register_addr = (state_q == StClear) ? AddrClear : AddrData;
  assign bus.wr_data       = (state_q == StClear) ? DATA_WIDTH'(snap_q) : '0;

  assign evt_data    = mem_q[rd_ptr_q[AW-1:0]];
  assign evt_valid   = !fifo_empty;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_input_irq_sequencer.sv
// Self-checking bench for input_irq_sequencer. A small behavioural controller supplies the
// edge register (addr 1 read, addr 3 write-one-to-clear, done = we & done_en); a queue holds
// the events the FIFO should contain.
module tb_input_irq_sequencer;

  localparam int unsigned Depth = 8;

  logic        clk;
  logic        rst_n;
  logic [11:0] evt_data;
  logic        evt_valid;
  logic        evt_ready;
  logic [31:0] evt_ts;
  logic        overflow;
  logic        timeout_err;
  logic        busy;
  logic        clr_err;

  // Controller model stimulus knobs (driven at negedges by the main sequence).
  logic [11:0] inj;
  logic        inj_v;
  logic        kill;
  logic        spur;
  logic        done_en;
  logic [11:0] edges;

  input_irq_sequencer_if #(.DATA_WIDTH(64)) bus ();

  input_irq_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .evt_data   (evt_data),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_ts     (evt_ts),
    .overflow   (overflow),
    .timeout_err(timeout_err),
    .busy       (busy),
    .clr_err    (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.irq     = (edges != 12'h0) | spur;
  assign bus.rd_data = (bus.register_addr == 2'd1) ? {52'h0, edges} : 64'h0;
  assign bus.done    = bus.we & done_en;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 12'h0;
    else edges <= ((kill ? 12'h0 : edges) &
                   ~((bus.we && bus.done && bus.register_addr == 2'd3) ?
                     bus.wr_data[11:0] : 12'h0)) | (inj_v ? inj : 12'h0);
  end

  // Cycles since reset release, used for the timestamp expectation.
  int unsigned cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Activity monitor (monotonic counters; the sequence takes deltas).
  int unsigned we_cycles   = 0;
  int unsigned busy_cycles = 0;
  int unsigned we_run      = 0;
  int unsigned we_run_last = 0;
  logic [63:0] last_wr_data = '0;
  logic [1:0]  last_wr_addr = '0;
  always @(posedge clk) begin
    if (bus.we) begin
      we_cycles    <= we_cycles + 1;
      we_run       <= we_run + 1;
      last_wr_data <= bus.wr_data;
      last_wr_addr <= bus.register_addr;
    end else if (we_run != 0) begin
      we_run_last <= we_run;
      we_run      <= 0;
    end
    if (busy) busy_cycles <= busy_cycles + 1;
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [11:0] model_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a new edge snapshot; returns at the negedge where irq is first high.
  task automatic inject(input logic [11:0] s);
    inj   = s;
    inj_v = 1'b1;
    @(negedge clk);
    inj_v = 1'b0;
  endtask

  task automatic wait_seq();
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("seq_start_busy", busy, 1);
    n = 0;
    while (busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    chk("seq_end_busy", busy, 0);
  endtask

  // One full interrupt service, with the model deciding push versus drop.
  task automatic run_event(input logic [11:0] s, output logic dropped);
    dropped = (model_q.size() >= Depth);
    if (!dropped) model_q.push_back(s);
    inject(s);
    wait_seq();
  endtask

  task automatic pop_check(input string tag);
    logic [11:0] e;
    e = model_q.pop_front();
    chk({tag, "_valid"}, evt_valid, 1);
    chk({tag, "_data"}, evt_data, e);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  initial begin
    int unsigned b0, w0, n;
    logic        drop, exp_ovf;
    logic [11:0] s;

    rst_n = 1'b0; evt_ready = 1'b0; clr_err = 1'b0;
    inj = '0; inj_v = 1'b0; kill = 1'b0; spur = 1'b0; done_en = 1'b1;

    // Reset values.
    #12;
    chk("rst_we", bus.we, 0);
    chk("rst_addr", bus.register_addr, 1);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_data", evt_data, 0);
    chk("rst_evt_ts", evt_ts, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic event with same-cycle done: latency and write shape.
    b0 = busy_cycles; w0 = we_cycles;
    model_q.push_back(12'h021);
    inject(12'h021);
    chk("lat_irq_busy", busy, 0);
    @(negedge clk);
    chk("lat_read_busy", busy, 1);
    chk("lat_read_we", bus.we, 0);
    chk("lat_read_addr", bus.register_addr, 1);
    chk("lat_read_valid", evt_valid, 0);
    @(negedge clk);
    chk("lat_clr_we", bus.we, 1);
    chk("lat_clr_addr", bus.register_addr, 3);
    chk("lat_clr_wdata", bus.wr_data, 64'h21);
    chk("lat_clr_valid", evt_valid, 1);
    chk("lat_clr_data", evt_data, 12'h021);
    @(negedge clk);
    chk("lat_settle_we", bus.we, 0);
    wait_seq();
    chk("basic_busy_len", busy_cycles - b0, 5);
    chk("basic_we_len", we_cycles - w0, 1);
    pop_check("basic_pop");
    chk("basic_empty", evt_valid, 0);

    // Spurious interrupt: no push, no write.
    w0 = we_cycles;
    spur = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    spur = 1'b0;
    wait_seq();
    chk("spur_we_cycles", we_cycles - w0, 0);
    chk("spur_valid", evt_valid, 0);
    chk("spur_overflow", overflow, 0);

    // Clear-write timeout: we held exactly TIMEOUT cycles.
    done_en = 1'b0;
    model_q.push_back(12'h005);
    inject(12'h005);
    n = 0;
    while (bus.we !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (bus.we === 1'b1 && n < 40) begin @(negedge clk); n++; end
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    wait_seq();
    done_en = 1'b1;
    chk("tmo_we_len", we_run_last, 16);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_addr", last_wr_addr, 3);
    chk("tmo_wdata", last_wr_data, 64'h5);
    pulse_clr();
    chk("tmo_clr", timeout_err, 0);
    pop_check("tmo_pop");

    // Overflow: snaps 1..9 with no pops.
    for (int i = 1; i <= 9; i++) begin
      run_event(12'(i), drop);
      if (i == 8) chk("ovf_before", overflow, 0);
    end
    chk("ovf_set", overflow, 1);
    chk("ovf_last_wdata", last_wr_data, 64'h9);
    chk("ovf_last_addr", last_wr_addr, 3);
    pulse_clr();
    chk("ovf_clr", overflow, 0);

    // Full FIFO with a pop in the push cycle: both accepted.
    inject(12'h0FF);
    @(negedge clk);
    chk("fullpp_read_busy", busy, 1);
    chk("fullpp_read_we", bus.we, 0);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    void'(model_q.pop_front());
    model_q.push_back(12'h0FF);
    wait_seq();
    chk("fullpp_overflow", overflow, 0);
    while (model_q.size() != 0) pop_check("fullpp_drain");
    chk("fullpp_empty", evt_valid, 0);

    // Randomised rounds against the queue model.
    exp_ovf = 1'b0;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(0, 4);
      for (int k = 0; k < int'(n); k++) begin
        s = 12'($urandom_range(1, 4095));
        run_event(s, drop);
        if (drop) exp_ovf = 1'b1;
      end
      chk("rnd_overflow", overflow, {63'h0, exp_ovf});
      if (exp_ovf) begin pulse_clr(); exp_ovf = 1'b0; end
      chk("rnd_valid", evt_valid, {63'h0, model_q.size() != 0});
      n = $urandom_range(0, model_q.size());
      for (int k = 0; k < int'(n); k++) pop_check("rnd_pop");
    end
    while (model_q.size() != 0) pop_check("rnd_drain");

    // Reset in the middle of a clear write.
    done_en = 1'b0;
    model_q.push_back(12'h003);
    inject(12'h003);
    n = 0;
    while (bus.we !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_we", bus.we, 0);
    chk("mrst_addr", bus.register_addr, 1);
    chk("mrst_valid", evt_valid, 0);
    chk("mrst_busy", busy, 0);
    model_q.delete();
    done_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Timestamp: irq high in cycle 100 after reset -> READ in cycle 101.
    n = 0;
    while (cyc != 99 && n < 200) begin @(negedge clk); n++; end
    model_q.push_back(12'h007);
    inject(12'h007);
    wait_seq();
    chk("ts_data", evt_data, 12'h007);
`ifdef INPUT_IRQ_SEQ_TIMESTAMP_EN
    chk("ts_value", evt_ts, 101);
`else
    chk("ts_value", evt_ts, 0);
`endif
    pop_check("ts_pop");
    chk("ts_empty", evt_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
